// File: rtl/design03_op_sequencer.sv
// Purpose : sequences one start(a,b) -> result(c) -> check(d) transaction on the datapath per command.
// Latency : accept edge n -> EN_start cycle n+1, result sampled n+2, EN_check n+3, rsp_valid n+4 (all RDYs high).
// Backpr. : cmd_ready only in IDLE; response held stable until rsp_ready; per-phase watchdog aborts stalled RDYs.
//
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake, operands cmd_a..cmd_d
//   rsp_valid/rsp_ready        response handshake, rsp_result/rsp_check/rsp_timeout
//   start_a/start_b/EN_start/RDY_start     datapath start method
//   result_c/result/RDY_result             datapath result method
//   check_d/EN_check/check/RDY_check       datapath check actionvalue
//   busy, op_count             status: not idle, responses handed off (wrapping)
module design03_op_sequencer #(
    parameter int W              = 7,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [W-1:0]     cmd_a,
    input  logic [W-1:0]     cmd_b,
    input  logic [W-1:0]     cmd_c,
    input  logic [W-1:0]     cmd_d,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_result,
    output logic [W-1:0]     rsp_check,
    output logic             rsp_timeout,
    output logic [W-1:0]     start_a,
    output logic [W-1:0]     start_b,
    output logic             EN_start,
    input  logic             RDY_start,
    output logic [W-1:0]     result_c,
    input  logic [W-1:0]     result,
    input  logic             RDY_result,
    output logic [W-1:0]     check_d,
    output logic             EN_check,
    input  logic [W-1:0]     check,
    input  logic             RDY_check,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_RESULT = 3'd2,
        S_CHECK  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    // The counter never needs to hold TIMEOUT_CYCLES itself: the phase is
    // abandoned on the cycle the count would reach it.
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES > 0);

    state_t            r_state;
    state_t            w_next;
    logic [W-1:0]      r_a, r_b, r_c, r_d;
    logic [W-1:0]      r_result, r_check;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_op_count;
    logic [WAIT_W-1:0] r_wait;

    logic w_accept, w_handoff, w_cap_res, w_cap_chk;
    logic w_waiting, w_phase_rdy, w_expire;

    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        rsp_valid   = 1'b0;
        EN_start    = 1'b0;
        EN_check    = 1'b0;
        w_accept    = 1'b0;
        w_handoff   = 1'b0;
        w_cap_res   = 1'b0;
        w_cap_chk   = 1'b0;
        w_waiting   = 1'b0;
        w_phase_rdy = 1'b1;
        w_expire    = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_START;
                end
            end
            S_START: begin
                EN_start    = RDY_start;
                w_waiting   = 1'b1;
                w_phase_rdy = RDY_start;
                if (RDY_start) w_next = S_RESULT;
            end
            S_RESULT: begin
                w_waiting   = 1'b1;
                w_phase_rdy = RDY_result;
                if (RDY_result) begin
                    w_cap_res = 1'b1;
                    w_next    = S_CHECK;
                end
            end
            S_CHECK: begin
                EN_check    = RDY_check;
                w_waiting   = 1'b1;
                w_phase_rdy = RDY_check;
                if (RDY_check) begin
                    w_cap_chk = 1'b1;
                    w_next    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_handoff = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // RDY rising on the limit cycle wins: expiry requires RDY still low.
        w_expire = WDOG_EN && w_waiting && !w_phase_rdy && (r_wait == WAIT_LAST);
        if (w_expire) w_next = S_RESP;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Cleared on every state change so each waiting phase starts from zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wait <= '0;
        end else if (w_next != r_state) begin
            r_wait <= '0;
        end else if (w_waiting && !w_phase_rdy) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_result   <= '0;
            r_check    <= '0;
            r_timeout  <= 1'b0;
            r_op_count <= '0;
        end else begin
            if (w_accept) begin
                r_a       <= cmd_a;
                r_b       <= cmd_b;
                r_c       <= cmd_c;
                r_d       <= cmd_d;
                r_result  <= '0;
                r_check   <= '0;
                r_timeout <= 1'b0;
            end
            if (w_cap_res) r_result <= result;
            if (w_cap_chk) r_check <= check;
            if (w_expire) r_timeout <= 1'b1;
            if (w_handoff) r_op_count <= r_op_count + 1'b1;
        end
    end

    assign start_a     = r_a;
    assign start_b     = r_b;
    assign result_c    = r_c;
    assign check_d     = r_d;
    assign rsp_result  = r_result;
    assign rsp_check   = r_check;
    assign rsp_timeout = r_timeout;
    assign op_count    = r_op_count;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_design03_op_sequencer.sv
// Purpose : randomized + directed transactions against a phase-timing reference model.
// Latency : n/a (testbench).
// Backpr. : drives rsp_ready low for chosen hold cycles and offers junk commands while busy.
module tb_design03_op_sequencer;

    localparam int W     = 7;
    localparam int TO    = 64;
    localparam int CNT_W = 3;
    localparam int NEVER = 1000;

    logic             CLK, RST_N;
    logic             cmd_valid, cmd_ready;
    logic [W-1:0]     cmd_a, cmd_b, cmd_c, cmd_d;
    logic             rsp_valid, rsp_ready;
    logic [W-1:0]     rsp_result, rsp_check;
    logic             rsp_timeout;
    logic [W-1:0]     start_a, start_b, result_c, check_d;
    logic             EN_start, RDY_start, RDY_result, EN_check, RDY_check;
    logic [W-1:0]     result, check;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    int n_cmp = 0;
    int n_err = 0;
    int cnt   = 0;

    design03_op_sequencer #(.W(W), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_check(rsp_check), .rsp_timeout(rsp_timeout),
        .start_a(start_a), .start_b(start_b), .EN_start(EN_start), .RDY_start(RDY_start),
        .result_c(result_c), .result(result), .RDY_result(RDY_result),
        .check_d(check_d), .EN_check(EN_check), .check(check), .RDY_check(RDY_check),
        .busy(busy), .op_count(op_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        expect_eq({where, ".cmd_ready"},   32'(cmd_ready),   32'd1);
        expect_eq({where, ".busy"},        32'(busy),        32'd0);
        expect_eq({where, ".rsp_valid"},   32'(rsp_valid),   32'd0);
        expect_eq({where, ".EN_start"},    32'(EN_start),    32'd0);
        expect_eq({where, ".EN_check"},    32'(EN_check),    32'd0);
        expect_eq({where, ".op_count"},    32'(op_count),    32'd0);
        expect_eq({where, ".rsp_result"},  32'(rsp_result),  32'd0);
        expect_eq({where, ".rsp_check"},   32'(rsp_check),   32'd0);
        expect_eq({where, ".rsp_timeout"}, 32'(rsp_timeout), 32'd0);
        expect_eq({where, ".start_a"},     32'(start_a),     32'd0);
        expect_eq({where, ".check_d"},     32'(check_d),     32'd0);
    endtask

    // Reference model: a phase either fires after `stall` low-RDY cycles
    // (stall < TO) or is abandoned after TO cycles, skipping to the response.
    // Cycle k counts cycles after the accept edge (k=1 is the first START cycle).
    // Called just after a rising edge with the DUT idle.
    task automatic run_txn(input logic [W-1:0] a, b, c, d,
                           input int s0, s1, s2, hold,
                           input bit fixed, input int rst_at);
        int t, ps_r, ps_c, ev_s, ev_r, ev_c, t_resp;
        bit tmo;
        logic [W-1:0] exp_res, exp_chk, dv_res, dv_chk;
        ev_s = -1; ev_r = -1; ev_c = -1; ps_r = -1; ps_c = -1; tmo = 1'b0; t = 1;
        if (s0 < TO) begin
            ev_s = t + s0; t = ev_s + 1; ps_r = t;
            if (s1 < TO) begin
                ev_r = t + s1; t = ev_r + 1; ps_c = t;
                if (s2 < TO) begin ev_c = t + s2; t = ev_c + 1; end
                else begin tmo = 1'b1; t = t + TO; end
            end else begin tmo = 1'b1; t = t + TO; end
        end else begin tmo = 1'b1; t = t + TO; end
        t_resp  = t;
        exp_res = '0;
        exp_chk = '0;

        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_c = c; cmd_d = d;
        rsp_ready = 1'b0;
        RDY_start = 1'($urandom); RDY_result = 1'($urandom); RDY_check = 1'($urandom);
        result = W'($urandom); check = W'($urandom);
        @(negedge CLK);
        expect_eq("idle.cmd_ready", 32'(cmd_ready), 32'd1);
        expect_eq("idle.busy",      32'(busy),      32'd0);
        expect_eq("idle.rsp_valid", 32'(rsp_valid), 32'd0);
        expect_eq("idle.op_count",  32'(op_count),  32'(cnt));
        @(posedge CLK); #1;

        for (int k = 1; k <= t_resp + hold; k++) begin
            cmd_valid = 1'($urandom);
            cmd_a = W'($urandom); cmd_b = W'($urandom);
            cmd_c = W'($urandom); cmd_d = W'($urandom);
            RDY_start  = (k >= 1 + s0);
            RDY_result = (ps_r > 0) && (k >= ps_r + s1);
            RDY_check  = (ps_c > 0) && (k >= ps_c + s2);
            dv_res = fixed ? 7'h15 : W'($urandom);
            dv_chk = fixed ? 7'h2A : W'($urandom);
            result = dv_res;
            check  = dv_chk;
            if (k == ev_r) exp_res = dv_res;
            if (k == ev_c) exp_chk = dv_chk;
            rsp_ready = (k == t_resp + hold);
            @(negedge CLK);
            expect_eq("EN_start",  32'(EN_start),  32'(k == ev_s));
            expect_eq("EN_check",  32'(EN_check),  32'(k == ev_c));
            expect_eq("busy",      32'(busy),      32'd1);
            expect_eq("cmd_ready", 32'(cmd_ready), 32'd0);
            expect_eq("rsp_valid", 32'(rsp_valid), 32'(k >= t_resp));
            expect_eq("start_a",   32'(start_a),   32'(a));
            expect_eq("start_b",   32'(start_b),   32'(b));
            expect_eq("result_c",  32'(result_c),  32'(c));
            expect_eq("check_d",   32'(check_d),   32'(d));
            if (k >= t_resp) begin
                expect_eq("rsp_result",  32'(rsp_result),  32'(exp_res));
                expect_eq("rsp_check",   32'(rsp_check),   32'(exp_chk));
                expect_eq("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
                expect_eq("rsp.op_count", 32'(op_count),   32'(cnt));
            end
            if (k == rst_at) begin
                #2 RST_N = 1'b0;
                #1 check_reset_outputs("midrst");
                cmd_valid = 1'b0;
                rsp_ready = 1'b0;
                #1 RST_N = 1'b1;
                @(posedge CLK); #1;
                cnt = 0;
                return;
            end
            @(posedge CLK); #1;
        end
        cnt = (cnt + 1) % (1 << CNT_W);
    endtask

    function automatic int pick_stall();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return r % 4;
        if (r < 15) return int'($urandom_range(4, 12));
        if (r == 15) return TO - 1;
        if (r == 16) return TO;
        if (r == 17) return NEVER;
        return 0;
    endfunction

    initial begin
        RST_N = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_c = '0; cmd_d = '0;
        RDY_start = 1'b0; RDY_result = 1'b0; RDY_check = 1'b0;
        result = '0; check = '0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK) RST_N = 1'b1;
        @(posedge CLK); #1;

        // no stall, reference values
        run_txn(7'd1, 7'd2, 7'd3, 7'd4, 0, 0, 0, 0, 1'b1, -1);
        // result stalled 10 cycles
        run_txn(7'd5, 7'd6, 7'd7, 7'd8, 0, 10, 0, 0, 1'b0, -1);
        // check never ready -> timeout
        run_txn(7'd9, 7'd10, 7'd11, 7'd12, 0, 0, NEVER, 0, 1'b0, -1);
        // response held 5 cycles with junk commands offered
        run_txn(7'h11, 7'h22, 7'h33, 7'h44, 1, 2, 3, 5, 1'b0, -1);
        // reset in mid-RESULT, then a clean transaction
        run_txn(7'h55, 7'h66, 7'h77, 7'h7f, 0, NEVER, 0, 0, 1'b0, 4);
        run_txn(7'd1, 7'd2, 7'd3, 7'd4, 0, 0, 0, 0, 1'b1, -1);
        // watchdog boundary: one below the limit fires, at the limit expires
        run_txn(7'h0a, 7'h0b, 7'h0c, 7'h0d, TO - 1, 0, 0, 0, 1'b0, -1);
        run_txn(7'h1a, 7'h1b, 7'h1c, 7'h1d, TO, 0, 0, 0, 1'b0, -1);
        run_txn(7'h2a, 7'h2b, 7'h2c, 7'h2d, 0, TO, 0, 1, 1'b0, -1);
        run_txn(7'h3a, 7'h3b, 7'h3c, 7'h3d, 0, 0, TO - 1, 0, 1'b0, -1);

        for (int i = 0; i < 30; i++) begin
            run_txn(W'($urandom), W'($urandom), W'($urandom), W'($urandom),
                    pick_stall(), pick_stall(), pick_stall(),
                    int'($urandom_range(0, 3)), 1'b0, -1);
        end

        @(negedge CLK);
        expect_eq("end.op_count", 32'(op_count), 32'(cnt));
        expect_eq("end.busy",     32'(busy),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
